// File: rtl/eth_recv.sv
// rtl/eth_recv.sv - Ethernet/ARP/IPv4/UDP receiver writing UDP payload words to a buffer
// Optional: ETH_RECV_IPCSUM_EN enables IPv4 header checksum verification.
module eth_recv #(
  parameter logic [15:0] LOCAL_PORT = 16'd2179,
  parameter logic [9:0]  MAX_WORDS  = 10'd1023
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [47:0] i_self_mac,
  input  logic [31:0] i_self_ip,
  input  logic [31:0] i_data,
  input  logic        i_vld,
  input  logic        i_sop,
  input  logic        i_eop,
  output logic        o_rdy,
  output logic        o_arp_req,
  output logic        o_arp_resp,
  output logic [47:0] o_peer_mac,
  output logic [31:0] o_peer_ip,
  output logic [9:0]  o_wr_addr,
  output logic [31:0] o_wr_data,
  output logic        o_wr_en,
  output logic        o_udp_done,
  output logic [15:0] o_udp_len,
  output logic        o_drop
);

  typedef enum logic [2:0] {S_IDLE, S_ETH, S_ARP, S_IP, S_PAY, S_DROP, S_HOLD} state_t;

  state_t      state_q, state_d, st, nxt;
  logic [15:0] cnt_q, cnt_d, w;
  logic        uc_q, uc_d, bc_q, bc_d;
  logic [47:0] src_mac_q, src_mac_d, sha_q, sha_d, peer_mac_q, peer_mac_d;
  logic [31:0] src_ip_q, src_ip_d, spa_q, spa_d, peer_ip_q, peer_ip_d;
  logic [15:0] oper_q, oper_d, pay_len_q, pay_len_d, pay_cnt_q, pay_cnt_d;
  logic [15:0] udp_len_q, udp_len_d;
  logic [9:0]  wr_addr_q, wr_addr_d;
  logic [31:0] wr_data_q, wr_data_d;
  logic        wr_en_q, wr_en_d;
  logic        arp_req_q, arp_req_d, arp_resp_q, arp_resp_d;
  logic        udp_done_q, udp_done_d, drop_q, drop_d;
  logic        xfer, fail;
  logic [16:0] n;
  logic [18:0] n4, l19;
`ifdef ETH_RECV_IPCSUM_EN
  logic [19:0] csum_q, csum_d, csum_s;
  logic [16:0] csum_f1;
  logic [15:0] csum_f2;
`endif

  assign o_rdy      = (state_q != S_HOLD);
  assign o_arp_req  = arp_req_q;
  assign o_arp_resp = arp_resp_q;
  assign o_peer_mac = peer_mac_q;
  assign o_peer_ip  = peer_ip_q;
  assign o_wr_addr  = wr_addr_q;
  assign o_wr_data  = wr_data_q;
  assign o_wr_en    = wr_en_q;
  assign o_udp_done = udp_done_q;
  assign o_udp_len  = udp_len_q;
  assign o_drop     = drop_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= 16'd0;
      uc_q       <= 1'b0;
      bc_q       <= 1'b0;
      src_mac_q  <= 48'd0;
      sha_q      <= 48'd0;
      peer_mac_q <= 48'd0;
      src_ip_q   <= 32'd0;
      spa_q      <= 32'd0;
      peer_ip_q  <= 32'd0;
      oper_q     <= 16'd0;
      pay_len_q  <= 16'd0;
      pay_cnt_q  <= 16'd0;
      udp_len_q  <= 16'd0;
      wr_addr_q  <= 10'd0;
      wr_data_q  <= 32'd0;
      wr_en_q    <= 1'b0;
      arp_req_q  <= 1'b0;
      arp_resp_q <= 1'b0;
      udp_done_q <= 1'b0;
      drop_q     <= 1'b0;
`ifdef ETH_RECV_IPCSUM_EN
      csum_q     <= 20'd0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      uc_q       <= uc_d;
      bc_q       <= bc_d;
      src_mac_q  <= src_mac_d;
      sha_q      <= sha_d;
      peer_mac_q <= peer_mac_d;
      src_ip_q   <= src_ip_d;
      spa_q      <= spa_d;
      peer_ip_q  <= peer_ip_d;
      oper_q     <= oper_d;
      pay_len_q  <= pay_len_d;
      pay_cnt_q  <= pay_cnt_d;
      udp_len_q  <= udp_len_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      wr_en_q    <= wr_en_d;
      arp_req_q  <= arp_req_d;
      arp_resp_q <= arp_resp_d;
      udp_done_q <= udp_done_d;
      drop_q     <= drop_d;
`ifdef ETH_RECV_IPCSUM_EN
      csum_q     <= csum_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    uc_d       = uc_q;
    bc_d       = bc_q;
    src_mac_d  = src_mac_q;
    sha_d      = sha_q;
    peer_mac_d = peer_mac_q;
    src_ip_d   = src_ip_q;
    spa_d      = spa_q;
    peer_ip_d  = peer_ip_q;
    oper_d     = oper_q;
    pay_len_d  = pay_len_q;
    pay_cnt_d  = pay_cnt_q;
    udp_len_d  = udp_len_q;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    wr_en_d    = 1'b0;
    arp_req_d  = 1'b0;
    arp_resp_d = 1'b0;
    udp_done_d = 1'b0;
    drop_d     = 1'b0;
    fail       = 1'b0;
    nxt        = state_q;
    xfer       = i_vld && o_rdy;
    w          = i_sop ? 16'd1 : ((cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1);
    st         = i_sop ? S_ETH : state_q;
    n          = {1'b0, pay_cnt_q} + 17'd1;
    n4         = {n, 2'b00};
    l19        = {3'b000, pay_len_q};
`ifdef ETH_RECV_IPCSUM_EN
    csum_d  = csum_q;
    csum_s  = csum_q + {4'd0, i_data[31:16]} + {4'd0, i_data[15:0]};
    csum_f1 = {1'b0, csum_s[15:0]} + {13'd0, csum_s[19:16]};
    csum_f2 = csum_f1[15:0] + {15'd0, csum_f1[16]};
`endif

    if (state_q == S_HOLD) begin
      state_d = S_IDLE;
    end else if (xfer && st != S_IDLE) begin
      cnt_d = w;
      nxt   = st;
      // A new sop abandons whatever frame was in flight.
      if (i_sop && state_q != S_IDLE) drop_d = 1'b1;
      case (st)
        S_ETH: begin
          case (w)
            16'd1: begin
              uc_d = (i_data[15:0] == i_self_mac[47:32]);
              bc_d = (i_data[15:0] == 16'hFFFF);
              fail = !(uc_d || bc_d);
            end
            16'd2: fail = !((uc_q && i_data == i_self_mac[31:0]) || (bc_q && i_data == 32'hFFFF_FFFF));
            16'd3: src_mac_d[47:16] = i_data;
            16'd4: begin
              src_mac_d[15:0] = i_data[31:16];
              if (i_data[15:0] == 16'h0806)      nxt = S_ARP;
              else if (i_data[15:0] == 16'h0800) nxt = S_IP;
              else                               fail = 1'b1;
            end
            default: ;
          endcase
        end
        S_ARP: begin
          case (w)
            16'd5: fail = (i_data != 32'h0001_0800);
            16'd6: begin
              fail   = (i_data[31:16] != 16'h0604);
              oper_d = i_data[15:0];
            end
            16'd7: sha_d[47:16] = i_data;
            16'd8: begin
              sha_d[15:0]  = i_data[31:16];
              spa_d[31:16] = i_data[15:0];
            end
            16'd9: spa_d[15:0] = i_data[31:16];
            16'd11: begin
              if (i_eop && oper_q == 16'd1 && i_data == i_self_ip) begin
                arp_req_d  = 1'b1;
                peer_mac_d = sha_q;
                peer_ip_d  = spa_q;
                nxt        = S_HOLD;
              end else if (i_eop && oper_q == 16'd2) begin
                arp_resp_d = 1'b1;
                peer_mac_d = sha_q;
                peer_ip_d  = spa_q;
                nxt        = S_HOLD;
              end else begin
                fail = 1'b1;
              end
            end
            default: ;
          endcase
        end
        S_IP: begin
          case (w)
            16'd5: begin
              fail = (i_data[31:24] != 8'h45);
`ifdef ETH_RECV_IPCSUM_EN
              csum_d = {4'd0, i_data[31:16]} + {4'd0, i_data[15:0]};
`endif
            end
            16'd6: begin
              fail = (i_data[13:0] != 14'd0);
`ifdef ETH_RECV_IPCSUM_EN
              csum_d = csum_s;
`endif
            end
            16'd7: begin
              fail = (i_data[23:16] != 8'd17);
`ifdef ETH_RECV_IPCSUM_EN
              csum_d = csum_s;
`endif
            end
            16'd8: begin
              src_ip_d = i_data;
`ifdef ETH_RECV_IPCSUM_EN
              csum_d = csum_s;
`endif
            end
            16'd9: begin
              fail = (i_data != i_self_ip);
`ifdef ETH_RECV_IPCSUM_EN
              if (csum_f2 != 16'hFFFF) fail = 1'b1;
`endif
            end
            16'd10: fail = (i_data[15:0] != LOCAL_PORT);
            16'd11: begin
              pay_len_d = i_data[31:16] - 16'd8;
              pay_cnt_d = 16'd0;
              if (i_data[31:16] < 16'd8) begin
                fail = 1'b1;
              end else if (i_eop) begin
                // Header-only datagram: complete without entering PAY.
                if (i_data[31:16] == 16'd8) begin
                  udp_done_d = 1'b1;
                  udp_len_d  = 16'd0;
                  peer_mac_d = src_mac_q;
                  peer_ip_d  = src_ip_q;
                  nxt        = S_HOLD;
                end else begin
                  fail = 1'b1;
                end
              end else begin
                nxt = S_PAY;
              end
            end
            default: ;
          endcase
        end
        S_PAY: begin
          pay_cnt_d = (pay_cnt_q == 16'hFFFF) ? pay_cnt_q : pay_cnt_q + 16'd1;
          if (pay_cnt_q <= {6'd0, MAX_WORDS}) begin
            wr_en_d   = 1'b1;
            wr_addr_d = pay_cnt_q[9:0];
            wr_data_d = i_data;
          end
          if (i_eop) begin
            nxt = S_HOLD;
            // Word count must equal ceil(payload_bytes/4) and fit the buffer.
            if (n <= ({7'd0, MAX_WORDS} + 17'd1) && n4 >= l19 && n4 < l19 + 19'd4) begin
              udp_done_d = 1'b1;
              udp_len_d  = pay_len_q;
              peer_mac_d = src_mac_q;
              peer_ip_d  = src_ip_q;
            end else begin
              drop_d = 1'b1;
            end
          end
        end
        S_DROP: begin
          if (i_eop) begin
            drop_d = 1'b1;
            nxt    = S_HOLD;
          end
        end
        default: ;
      endcase

      if (st == S_ETH || st == S_ARP || st == S_IP) begin
        if ((i_eop && w < 16'd11) || (fail && i_eop)) begin
          drop_d  = 1'b1;
          state_d = S_HOLD;
        end else if (fail) begin
          state_d = S_DROP;
        end else begin
          state_d = nxt;
        end
      end else begin
        state_d = nxt;
      end
    end
  end

endmodule

// File: tb/tb_eth_recv.sv
// tb/tb_eth_recv.sv - directed self-checking bench for eth_recv
`timescale 1ns/1ps
module tb_eth_recv;

  localparam logic [47:0] SELF_MAC = 48'h0200_0000_0001;
  localparam logic [31:0] SELF_IP  = 32'hC0A8_0001;
  localparam logic [47:0] PEER_MAC = 48'h0200_0000_0005;
  localparam logic [31:0] PEER_IP  = 32'hC0A8_0005;
  localparam logic [15:0] PORT     = 16'd2179;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] i_data = 32'd0;
  logic        i_vld = 1'b0, i_sop = 1'b0, i_eop = 1'b0;
  logic        o_rdy, o_arp_req, o_arp_resp, o_wr_en, o_udp_done, o_drop;
  logic [47:0] o_peer_mac;
  logic [31:0] o_peer_ip, o_wr_data;
  logic [9:0]  o_wr_addr;
  logic [15:0] o_udp_len;

  always #5 clk = ~clk;

  eth_recv #(.LOCAL_PORT(16'd2179), .MAX_WORDS(10'd1023)) dut (
    .clk(clk), .rst_n(rst_n), .i_self_mac(SELF_MAC), .i_self_ip(SELF_IP),
    .i_data(i_data), .i_vld(i_vld), .i_sop(i_sop), .i_eop(i_eop), .o_rdy(o_rdy),
    .o_arp_req(o_arp_req), .o_arp_resp(o_arp_resp), .o_peer_mac(o_peer_mac),
    .o_peer_ip(o_peer_ip), .o_wr_addr(o_wr_addr), .o_wr_data(o_wr_data),
    .o_wr_en(o_wr_en), .o_udp_done(o_udp_done), .o_udp_len(o_udp_len), .o_drop(o_drop)
  );

  int n_vec = 0, n_bad = 0;
  int m_req = 0, m_resp = 0, m_done = 0, m_drop = 0, m_rdylow = 0, m_excl = 0;
  int b_req, b_resp, b_done, b_drop, b_rdylow, b_wr;
  logic [9:0]  wa_q[$];
  logic [31:0] wd_q[$];
  logic [31:0] fr_q[$];

  always @(negedge clk) begin
    if (o_arp_req)  m_req++;
    if (o_arp_resp) m_resp++;
    if (o_udp_done) m_done++;
    if (o_drop)     m_drop++;
    if (!o_rdy)     m_rdylow++;
    if ((32'(o_arp_req) + 32'(o_arp_resp) + 32'(o_udp_done) + 32'(o_drop)) > 1) m_excl++;
    if (o_wr_en) begin
      wa_q.push_back(o_wr_addr);
      wd_q.push_back(o_wr_data);
    end
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic snap();
    b_req = m_req; b_resp = m_resp; b_done = m_done; b_drop = m_drop;
    b_rdylow = m_rdylow; b_wr = wa_q.size();
  endtask

  task automatic check_counts(input string tag, input int req, input int resp,
                              input int done, input int drop, input int wr);
    repeat (4) @(posedge clk);
    #1;
    check_val({tag, ".arp_req"},  64'(m_req - b_req),        64'(req));
    check_val({tag, ".arp_resp"}, 64'(m_resp - b_resp),      64'(resp));
    check_val({tag, ".udp_done"}, 64'(m_done - b_done),      64'(done));
    check_val({tag, ".drop"},     64'(m_drop - b_drop),      64'(drop));
    check_val({tag, ".writes"},   64'(wa_q.size() - b_wr),   64'(wr));
  endtask

  task automatic check_writes(input string tag, input int cnt, input logic [7:0] fid);
    for (int k = 0; k < cnt; k++) begin
      if (b_wr + k < wa_q.size()) begin
        check_val({tag, ".wr_addr"}, 64'(wa_q[b_wr + k]), 64'(k));
        check_val({tag, ".wr_data"}, 64'(wd_q[b_wr + k]), {32'd0, 8'hD0, fid, 16'(k)});
      end else begin
        check_val({tag, ".wr_missing"}, 64'd0, 64'd1);
      end
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check_val({tag, ".rdy"},      64'(o_rdy), 64'd1);
    check_val({tag, ".peer_mac"}, 64'(o_peer_mac), 64'd0);
    check_val({tag, ".peer_ip"},  64'(o_peer_ip), 64'd0);
    check_val({tag, ".wr_addr"},  64'(o_wr_addr), 64'd0);
    check_val({tag, ".udp_len"},  64'(o_udp_len), 64'd0);
    check_val({tag, ".pulses"},   64'({o_arp_req, o_arp_resp, o_udp_done, o_drop, o_wr_en}), 64'd0);
  endtask

  function automatic logic [15:0] ip_csum(input logic [31:0] a, input logic [31:0] b,
                                          input logic [31:0] c, input logic [31:0] d,
                                          input logic [31:0] e);
    logic [19:0] s;
    s = {4'd0, a[31:16]} + {4'd0, a[15:0]} + {4'd0, b[31:16]} + {4'd0, b[15:0]}
      + {4'd0, c[31:16]} + {4'd0, c[15:0]} + {4'd0, d[31:16]} + {4'd0, d[15:0]}
      + {4'd0, e[31:16]} + {4'd0, e[15:0]};
    s = {4'd0, s[15:0]} + {16'd0, s[19:16]};
    s = {4'd0, s[15:0]} + {16'd0, s[19:16]};
    return ~s[15:0];
  endfunction

  task automatic mk_arp(input logic [15:0] oper, input logic [31:0] tpa);
    fr_q.push_back(32'h0000_FFFF);
    fr_q.push_back(32'hFFFF_FFFF);
    fr_q.push_back(32'h0200_0000);
    fr_q.push_back(32'h0005_0806);
    fr_q.push_back(32'h0001_0800);
    fr_q.push_back({16'h0604, oper});
    fr_q.push_back(32'h0200_0000);
    fr_q.push_back(32'h0005_C0A8);
    fr_q.push_back(32'h0005_0000);
    fr_q.push_back(32'h0000_0000);
    fr_q.push_back(tpa);
  endtask

  task automatic mk_udp(input logic [47:0] dmac, input logic [31:0] dip, input logic [15:0] dport,
                        input logic [15:0] ulen, input int npay, input logic [7:0] fid,
                        input logic [15:0] csum_xor);
    logic [31:0] w5, w6, w7, w8, w9;
    w5 = {8'h45, 8'h00, 16'd20 + ulen};
    w6 = 32'h1234_4000;
    w7 = 32'h4011_0000;
    w8 = PEER_IP;
    w9 = dip;
    w7[15:0] = ip_csum(w5, w6, w7, w8, w9) ^ csum_xor;
    fr_q.push_back({16'h0000, dmac[47:32]});
    fr_q.push_back(dmac[31:0]);
    fr_q.push_back(PEER_MAC[47:16]);
    fr_q.push_back({PEER_MAC[15:0], 16'h0800});
    fr_q.push_back(w5);
    fr_q.push_back(w6);
    fr_q.push_back(w7);
    fr_q.push_back(w8);
    fr_q.push_back(w9);
    fr_q.push_back({16'h1F40, dport});
    fr_q.push_back({ulen, 16'h0000});
    for (int k = 0; k < npay; k++) fr_q.push_back({8'hD0, fid, 16'(k)});
  endtask

  task automatic send_range(input int from, input int upto, input bit sop_first, input bit eop_last);
    for (int i = from; i < upto; i++) begin
      bit acc;
      int tries;
      acc = 1'b0;
      tries = 0;
      i_data = fr_q[i];
      i_sop  = sop_first && (i == from);
      i_eop  = eop_last && (i == upto - 1);
      i_vld  = 1'b1;
      while (!acc && tries < 8) begin
        @(negedge clk);
        acc = o_rdy;
        @(posedge clk);
        #1;
        tries++;
      end
      if (!acc) check_val("rdy_timeout", 64'd0, 64'd1);
    end
    i_vld = 1'b0;
    i_sop = 1'b0;
    i_eop = 1'b0;
  endtask

  task automatic send_frame(input bit eop_last);
    send_range(0, fr_q.size(), 1'b1, eop_last);
    fr_q.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    snap(); mk_arp(16'd1, SELF_IP); send_frame(1'b1);
    check_counts("arp_req", 1, 0, 0, 0, 0);
    check_val("arp_req.peer_mac", 64'(o_peer_mac), 64'h0000_0200_0000_0005);
    check_val("arp_req.peer_ip",  64'(o_peer_ip),  64'h0000_0000_C0A8_0005);
    check_val("arp_req.rdy_low",  64'(m_rdylow - b_rdylow), 64'd1);

    snap(); mk_udp(SELF_MAC, SELF_IP, PORT, 16'd24, 4, 8'h01, 16'h0); send_frame(1'b1);
    check_counts("udp16", 0, 0, 1, 0, 4);
    check_writes("udp16", 4, 8'h01);
    check_val("udp16.udp_len", 64'(o_udp_len), 64'd16);
    check_val("udp16.rdy_low", 64'(m_rdylow - b_rdylow), 64'd1);

    snap(); mk_udp(SELF_MAC, 32'hC0A8_0009, PORT, 16'd24, 4, 8'h02, 16'h0); send_frame(1'b1);
    check_counts("bad_ip", 0, 0, 0, 1, 0);

    snap();
    mk_arp(16'd1, SELF_IP);
    send_range(0, 5, 1'b1, 1'b0);
    fr_q.delete();
    mk_udp(SELF_MAC, SELF_IP, PORT, 16'd16, 2, 8'h03, 16'h0); send_frame(1'b1);
    check_counts("sop_restart", 0, 0, 1, 1, 2);
    check_writes("sop_restart", 2, 8'h03);

    snap(); mk_udp(SELF_MAC, SELF_IP, PORT, 16'd24, 4, 8'h04, 16'h0001); send_frame(1'b1);
`ifdef ETH_RECV_IPCSUM_EN
    check_counts("bad_csum", 0, 0, 0, 1, 0);
`else
    check_counts("bad_csum", 0, 0, 1, 0, 4);
`endif

    snap(); mk_arp(16'd2, 32'h0A00_0001); send_frame(1'b1);
    check_counts("arp_resp", 0, 1, 0, 0, 0);

    snap(); mk_arp(16'd1, 32'hC0A8_0063); send_frame(1'b1);
    check_counts("arp_wrong_tpa", 0, 0, 0, 1, 0);

    snap();
    mk_udp(SELF_MAC, SELF_IP, PORT, 16'd24, 4, 8'h05, 16'h0);
    send_range(0, 7, 1'b1, 1'b1);
    fr_q.delete();
    check_counts("early_eop", 0, 0, 0, 1, 0);
    check_val("early_eop.rdy_low", 64'(m_rdylow - b_rdylow), 64'd1);

    snap(); mk_udp(SELF_MAC, SELF_IP, PORT, 16'd24, 3, 8'h06, 16'h0); send_frame(1'b1);
    check_counts("short_pay", 0, 0, 0, 1, 3);

    snap(); mk_udp(48'h0200_0000_0009, SELF_IP, PORT, 16'd24, 4, 8'h07, 16'h0); send_frame(1'b1);
    check_counts("bad_mac", 0, 0, 0, 1, 0);

    snap(); mk_udp(SELF_MAC, SELF_IP, 16'd80, 16'd24, 4, 8'h08, 16'h0); send_frame(1'b1);
    check_counts("bad_port", 0, 0, 0, 1, 0);

    snap(); mk_udp(SELF_MAC, SELF_IP, PORT, 16'd13, 2, 8'h09, 16'h0); send_frame(1'b1);
    check_counts("odd_len", 0, 0, 1, 0, 2);
    check_val("odd_len.udp_len", 64'(o_udp_len), 64'd5);

    snap(); mk_udp(48'hFFFF_FFFF_FFFF, SELF_IP, PORT, 16'd12, 1, 8'h0A, 16'h0); send_frame(1'b1);
    check_counts("bcast", 0, 0, 1, 0, 1);
    check_val("bcast.udp_len", 64'(o_udp_len), 64'd4);

    snap(); mk_udp(SELF_MAC, SELF_IP, PORT, 16'd8, 0, 8'h0B, 16'h0); send_frame(1'b1);
    check_counts("zero_pay", 0, 0, 1, 0, 0);
    check_val("zero_pay.udp_len", 64'(o_udp_len), 64'd0);

    snap();
    mk_arp(16'd1, SELF_IP);
    send_range(0, 3, 1'b0, 1'b1);
    fr_q.delete();
    check_counts("no_sop", 0, 0, 0, 0, 0);
    check_val("no_sop.rdy_low", 64'(m_rdylow - b_rdylow), 64'd0);

    mk_udp(SELF_MAC, SELF_IP, PORT, 16'd128, 30, 8'h0C, 16'h0);
    send_range(0, 20, 1'b1, 1'b0);
    rst_n = 1'b0;
    #1;
    check_idle_outputs("mid_reset");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    snap();
    send_range(20, fr_q.size(), 1'b0, 1'b1);
    fr_q.delete();
    check_counts("after_reset_tail", 0, 0, 0, 0, 0);
    snap(); mk_udp(SELF_MAC, SELF_IP, PORT, 16'd24, 4, 8'h0D, 16'h0); send_frame(1'b1);
    check_counts("after_reset", 0, 0, 1, 0, 4);
    check_writes("after_reset", 4, 8'h0D);

    snap(); mk_udp(SELF_MAC, SELF_IP, PORT, 16'd4108, 1025, 8'h0E, 16'h0); send_frame(1'b1);
    check_counts("overflow", 0, 0, 0, 1, 1024);
    if (wa_q.size() > 0) check_val("overflow.last_addr", 64'(wa_q[wa_q.size() - 1]), 64'd1023);
    else check_val("overflow.no_writes", 64'd0, 64'd1);

    check_val("pulse_exclusive", 64'(m_excl), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
